// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// if_pkg : shared constants and redirect-cause encoding for the fetch unit
// Rev 1.0
// ============================================================================
package if_pkg;

  localparam logic [31:0] RESET_ADDR  = 32'h8000_0000;
  localparam logic [31:0] ILLOP_ADDR  = 32'h8000_0004;
  localparam logic [31:0] XADR        = 32'h8000_0008;
  localparam logic [31:0] NOP_INSN    = 32'h83FF_F800;
  localparam logic [31:0] BNE_XP_INSN = 32'h77DF_0000;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    EXP  = 3'd1,
    JMP  = 3'd2,
    BR   = 3'd3,
    IRQ  = 3'd4
  } redirect_e;

endpackage
`default_nettype wire

// File: rtl/if_prefetch_if.sv
`default_nettype none
// ============================================================================
// if_prefetch_if : imem fetch and RF hand-off channels of the prefetch unit
// Rev 1.0
// ============================================================================
interface if_prefetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_RF;
  logic [XLEN-1:0] pc_RF;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_RF, pc_RF,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_RF, pc_RF,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : circular prefetch buffer with synchronous flush and 1-entry load
// Rev 1.0
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       load,
  input  logic [WIDTH-1:0]           load_data,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_w, do_push, do_pop;

  assign empty  = (cnt_q == '0);
  assign full_w = (cnt_q == CW'(DEPTH));
  assign count  = cnt_q;
  assign head   = mem_q[rd_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full_w || do_pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    // A load is a flush that leaves exactly one entry behind.
    if (flush || load) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      if (load) begin
        mem_d[0] = load_data;
        wr_d     = AW'(1);
        cnt_d    = CW'(1);
      end
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
// if_prefetch : instruction prefetch unit with redirect, kill and IRQ insertion
// Rev 1.0
// ============================================================================
module if_prefetch
  import if_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exp,
  input  logic            jt,
  input  logic            bt,
  input  logic            irq,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] pc_offset,
  output logic [XLEN-1:0] pc,
  if_prefetch_if.master   bus
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * XLEN;

  localparam logic [XLEN-1:0] RST_A   = XLEN'(RESET_ADDR);
  localparam logic [XLEN-1:0] ILLOP_A = XLEN'(ILLOP_ADDR);
  localparam logic [XLEN-1:0] XADR_A  = XLEN'(XADR);
  localparam logic [XLEN-1:0] NOP_A   = XLEN'(NOP_INSN);
  localparam logic [XLEN-1:0] BNE_A   = XLEN'(BNE_XP_INSN);

  // The supervisor bit rides along unchanged through sequential fetch.
  function automatic logic [XLEN-1:0] inc_addr(input logic [XLEN-1:0] a);
    logic [XLEN-1:0] s;
    s = a + XLEN'(4);
    return {a[XLEN-1], s[XLEN-2:0]};
  endfunction

  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]   out_q, out_d, kill_q, kill_d, out_next;

  redirect_e       cause;
  logic [XLEN-1:0] target, irq_addr;
  logic            redirect, req_valid, req_fire, rsp_fire, id_valid_w;
  logic            fifo_flush, fifo_load, fifo_push, fifo_pop, fifo_empty;
  logic [EW-1:0]   fifo_head;
  logic [CW-1:0]   fifo_cnt;

  always_comb begin
    cause  = NONE;
    target = pc_q;
    if (exp) begin
      cause  = EXP;
      target = ILLOP_A;
    end else if (jt) begin
      cause  = JMP;
      target = {pc_q[XLEN-1] & rd1[XLEN-1], rd1[XLEN-2:0]};
    end else if (bt) begin
      cause  = BR;
      target = {pc_q[XLEN-1], pc_offset[XLEN-2:0]};
    end else if (irq) begin
      cause  = IRQ;
      target = XADR_A;
    end
  end

  assign redirect   = (cause != NONE);
  assign req_valid  = !reset && !redirect
                      && (32'(out_q) < 32'(MAX_OUT))
                      && ((32'(fifo_cnt) + 32'(out_q)) < 32'(DEPTH));
  assign req_fire   = req_valid && bus.imem_req_ready;
  assign rsp_fire   = bus.imem_rsp_valid && (out_q != '0);
  assign out_next   = out_q + OW'(req_fire) - OW'(rsp_fire);
  assign id_valid_w = !reset && !fifo_empty;
  assign irq_addr   = fifo_empty ? rsp_pc_q : fifo_head[XLEN-1:0];

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_next;
    kill_d     = kill_q;
    fifo_flush = 1'b0;
    fifo_load  = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fifo_flush = 1'b1;
      fifo_load  = (cause == IRQ);
      pc_d       = target;
      rsp_pc_d   = target;
      kill_d     = out_next;
    end else begin
      if (req_fire) begin
        pc_d = inc_addr(pc_q);
      end
      if (rsp_fire) begin
        if (kill_q == '0) begin
          fifo_push = 1'b1;
          rsp_pc_d  = inc_addr(rsp_pc_q);
        end else begin
          kill_d = kill_q - OW'(1);
        end
      end
      fifo_pop = id_valid_w && bus.id_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RST_A;
      rsp_pc_q <= RST_A;
      out_q    <= '0;
      kill_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      kill_q   <= kill_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .load      (fifo_load),
    .load_data ({BNE_A, irq_addr}),
    .push      (fifo_push),
    .push_data ({bus.imem_rsp_data, rsp_pc_q}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign pc                 = pc_q;
  assign bus.imem_addr      = pc_q;
  assign bus.imem_req_valid = req_valid;
  assign bus.id_valid       = id_valid_w;
  assign bus.id_RF          = id_valid_w ? fifo_head[EW-1:XLEN] : NOP_A;
  assign bus.pc_RF          = id_valid_w ? inc_addr(fifo_head[XLEN-1:0]) : '0;
endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
// tb_if_prefetch : randomized scoreboard bench for the prefetch unit
// Rev 1.0
// ============================================================================
module tb_if_prefetch;
  import if_pkg::*;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exp_s = 1'b0, jt_s = 1'b0, bt_s = 1'b0, irq_s = 1'b0;
  logic [31:0] rd1_s = '0, off_s = '0;
  logic [31:0] pc_s;

  if_prefetch_if #(.XLEN(XLEN)) bus();

  if_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .exp       (exp_s),
    .jt        (jt_s),
    .bt        (bt_s),
    .irq       (irq_s),
    .rd1       (rd1_s),
    .pc_offset (off_s),
    .pc        (pc_s),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int hs      = 0;

  // ---------------- reference model: the instruction stream RF should see
  typedef struct { logic [31:0] insn; logic [31:0] pcrf; logic [31:0] addr; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] stream_addr;
  logic        sup;

  function automatic logic [31:0] inc4(input logic [31:0] a);
    logic [31:0] s;
    s = a + 32'd4;
    return (a & 32'h8000_0000) | (s & 32'h7FFF_FFFF);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{mem_word(stream_addr), inc4(stream_addr), stream_addr});
      stream_addr = inc4(stream_addr);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    stream_addr = RESET_ADDR;
    sup         = 1'b1;
    top_up();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- imem environment: in-order responses, latency >= 1
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int    cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;

  always @(negedge clk) begin
    if (!reset && bus.imem_req_valid && bus.imem_req_ready) begin
      int d;
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{bus.imem_addr, d});
    end
  end

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (reset) begin
        pend.delete();
        bus.imem_rsp_valid = 1'b0;
      end else if (pend.size() != 0 && pend[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
      end
    end
  end

  // ---------------- monitor: compares every consumed instruction
  always @(negedge clk) begin
    if (!reset) begin
      if (!bus.id_valid) check("empty_nop", bus.id_RF, NOP_INSN);
      if (bus.id_valid && bus.id_ready && !(exp_s || jt_s || bt_s || irq_s)) begin
        exp_t e;
        hs++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_insn", bus.id_RF, e.insn);
          check("sb_pc_rf", bus.pc_RF, e.pcrf);
          top_up();
        end
      end
    end
  end

  // ---------------- stimulus: drives one cycle and updates the model
  task automatic step(input bit r, input bit e, input bit j, input bit b, input bit i,
                      input logic [31:0] r1, input logic [31:0] off,
                      input bit idr, input bit rr);
    logic [31:0] tgt, head;
    @(posedge clk);
    #1;
    reset = r; exp_s = e; jt_s = j; bt_s = b; irq_s = i;
    rd1_s = r1; off_s = off;
    bus.id_ready = idr; bus.imem_req_ready = rr;
    if (r) begin
      model_reset();
    end else if (e || j || b || i) begin
      head = exp_q[0].addr;
      if (e)      tgt = ILLOP_ADDR;
      else if (j) tgt = {sup & r1[31], r1[30:0]};
      else if (b) tgt = {sup, off[30:0]};
      else        tgt = XADR;
      exp_q.delete();
      if (i && !e && !j && !b) exp_q.push_back('{BNE_XP_INSN, inc4(head), head});
      stream_addr = tgt;
      sup         = tgt[31];
      top_up();
    end
  endtask

  task automatic idle(input bit idr);
    step(0, 0, 0, 0, 0, 32'd0, 32'd0, idr, 1);
  endtask

  task automatic wait_id(input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      idle(0);
      @(negedge clk);
      found = bus.id_valid;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.id_ready       = 1'b0;
    bus.imem_req_ready = 1'b0;
    model_reset();

    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 1, 1, 0, 1, 32'h1234, 0, 1, 1);
    @(negedge clk);
    check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("rst_id_valid",  {31'd0, bus.id_valid}, 32'd0);
    check("rst_id_rf",     bus.id_RF, NOP_INSN);
    check("rst_pc_rf",     bus.pc_RF, 32'd0);
    check("rst_imem_addr", bus.imem_addr, RESET_ADDR);

    // streaming, latency 1
    for (int k = 0; k < 12; k++) begin
      idle(1);
      @(negedge clk);
      if (k == 0) begin
        check("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("first_req_addr",  bus.imem_addr, RESET_ADDR);
      end
      check("stream_id_valid", {31'd0, bus.id_valid}, (k < 2) ? 32'd0 : 32'd1);
    end

    // stall fills the FIFO and holds the head
    for (int k = 0; k < 6; k++) begin
      idle(0);
      @(negedge clk);
      check("stall_hold", bus.id_RF, exp_q[0].insn);
      if (k == 5) begin
        check("stall_req_off", {31'd0, bus.imem_req_valid}, 32'd0);
        check("stall_id_valid", {31'd0, bus.id_valid}, 32'd1);
      end
    end
    for (int k = 0; k < 8; k++) idle(1);

    // jump with two requests in flight
    lat_min = 2; lat_max = 2;
    for (int k = 0; k < 6; k++) idle(1);
    step(0, 0, 1, 0, 0, 32'h0000_1000, 0, 1, 1);
    idle(0);
    @(negedge clk);
    check("jmp_imem_addr", bus.imem_addr, 32'h0000_1000);
    wait_id("jmp_wait");
    check("jmp_first_insn", bus.id_RF, mem_word(32'h0000_1000));
    check("jmp_first_pcrf", bus.pc_RF, 32'h0000_1004);

    // interrupt with head at 0x40
    step(0, 0, 1, 0, 0, 32'h0000_0040, 0, 0, 1);
    wait_id("irq_wait");
    step(0, 0, 0, 0, 1, 0, 0, 0, 1);
    idle(0);
    @(negedge clk);
    check("irq_id_valid", {31'd0, bus.id_valid}, 32'd1);
    check("irq_insn",     bus.id_RF, BNE_XP_INSN);
    check("irq_pcrf",     bus.pc_RF, 32'h0000_0044);
    check("irq_resume",   bus.imem_addr, XADR);
    for (int k = 0; k < 10; k++) idle(1);

    // priority exp > jt > irq
    step(0, 1, 1, 0, 1, $urandom, 0, 1, 1);
    idle(1);
    @(negedge clk);
    check("prio_pc",       pc_s, ILLOP_ADDR);
    check("prio_bubble1",  {31'd0, bus.id_valid}, 32'd0);
    idle(1);
    @(negedge clk);
    check("prio_bubble2",  {31'd0, bus.id_valid}, 32'd0);
    for (int k = 0; k < 8; k++) idle(1);

    // reset mid-stream with requests in flight and entries queued
    for (int k = 0; k < 4; k++) idle(0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    @(negedge clk);
    check("mrst_id_valid",  {31'd0, bus.id_valid}, 32'd0);
    check("mrst_id_rf",     bus.id_RF, NOP_INSN);
    check("mrst_imem_addr", bus.imem_addr, RESET_ADDR);
    check("mrst_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);

    // randomized traffic
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 4000; k++) begin
      bit r, red, e, j, b, i;
      r   = ($urandom_range(0, 399) == 0);
      red = ($urandom_range(0, 15) == 0);
      e   = red && ($urandom_range(0, 3) == 0);
      j   = red && ($urandom_range(0, 2) == 0);
      b   = red && ($urandom_range(0, 2) == 0);
      i   = red && ($urandom_range(0, 2) == 0);
      if (red && !e && !j && !b) i = 1'b1;
      step(r, e, j, b, i, $urandom, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    for (int k = 0; k < 30; k++) idle(1);
    @(negedge clk);
    check("handshakes_seen", {31'd0, hs >= 1000}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter XLEN, default 32: instruction/address width; bit XLEN-1 is the supervisor bit.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter MAX_OUT, default 2: maximum outstanding imem requests, at least 1.
REQ-004 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port exp, input, 1: illegal-op exception from RF.
REQ-007 SHALL have ports jt and bt, input, 1 each: jump taken and branch taken.
REQ-008 SHALL have port irq, input, 1: interrupt request.
REQ-009 SHALL have ports rd1 and pc_offset, input, XLEN each: jump target and branch target.
REQ-010 SHALL have ports imem_req_valid (output, 1), imem_req_ready (input, 1) and imem_addr (output, XLEN): the fetch request.
REQ-011 SHALL have ports imem_rsp_valid (input, 1) and imem_rsp_data (input, XLEN): responses, in order, latency 1 cycle or more.
REQ-012 SHALL have ports id_valid (output, 1), id_ready (input, 1), id_RF (output, XLEN) and pc_RF (output, XLEN): the instruction handed to RF.
REQ-013 SHALL have port pc, output, XLEN: the next fetch address; imem_addr SHALL equal pc.

Function
REQ-014 Incrementing an address SHALL compute {a[XLEN-1], (a+4)[XLEN-2:0]}, so the supervisor bit never changes.
REQ-015 imem_req_valid SHALL equal: outstanding < MAX_OUT and fifo_count + outstanding < DEPTH and no redirect this cycle.
REQ-016 An accepted request (imem_req_valid & imem_req_ready) SHALL increment pc and increment outstanding.
REQ-017 Register rsp_pc SHALL hold the address of the next expected response.
REQ-018 On a response with kill_cnt = 0, the block SHALL push {imem_rsp_data, rsp_pc} into the FIFO and increment rsp_pc.
REQ-019 On a response with kill_cnt > 0, the block SHALL drop the response and decrement kill_cnt.
REQ-020 Every response SHALL decrement outstanding; a response arriving with outstanding = 0 is a protocol error and SHALL be ignored.
REQ-021 id_valid SHALL equal FIFO not empty.
REQ-022 id_RF SHALL equal the head instruction, and pc_RF SHALL equal the increment (REQ-014) of the head address.
REQ-023 The head SHALL pop on id_valid & id_ready; while id_ready = 0, the head, id_RF and pc_RF SHALL hold.
REQ-024 Redirect priority SHALL be exp > jt > bt > irq.
REQ-025 Redirect targets SHALL be:
- exp: ILLOP_ADDR.
- jt: {pc[XLEN-1] & rd1[XLEN-1], rd1[XLEN-2:0]}.
- bt: {pc[XLEN-1], pc_offset[XLEN-2:0]}.
- irq: XADR.
REQ-026 Any redirect SHALL act regardless of id_ready, with the following effects:
- flush the FIFO;
- load pc and rsp_pc with the target;
- set kill_cnt to the outstanding count after this cycle's accounting, i.e. including a request accepted this cycle and excluding a response arriving this cycle.
REQ-027 A response arriving in the same cycle as a redirect SHALL be dropped and SHALL NOT consume kill_cnt.
REQ-028 A pop in the same cycle as a redirect SHALL be discarded; the flush wins.
REQ-029 An irq redirect SHALL additionally leave exactly one FIFO entry: instruction BNE_XP_INSN, whose address is the old head address if the FIFO was non-empty, else the old rsp_pc.
REQ-030 exp, jt and bt SHALL leave the FIFO empty, so RF sees a bubble (id_valid = 0) for at least 2 cycles.
REQ-031 Full FIFO: no request is issued (REQ-015), so the FIFO never overflows.
REQ-032 Empty FIFO: id_valid = 0, and id_RF SHALL read NOP_INSN.

Reset
REQ-033 While reset = 1, the block SHALL set:
- pc = rsp_pc = RESET_ADDR;
- FIFO empty;
- outstanding = 0;
- kill_cnt = 0;
- imem_req_valid = 0;
- id_valid = 0, id_RF = NOP_INSN, pc_RF = 0.
REQ-034 Reset SHALL override every redirect and handshake in the same cycle.
REQ-035 After reset deasserts, the first request SHALL issue in the next cycle with imem_addr = RESET_ADDR.
REQ-036 Responses to requests issued before reset SHALL NOT be seen; the environment quiesces imem across reset.

Structure
REQ-037 Package if_pkg SHALL hold:
- RESET_ADDR = 0x80000000, ILLOP_ADDR = 0x80000004, XADR = 0x80000008;
- NOP_INSN = 0x83FFF800, BNE_XP_INSN = 0x77DF0000;
- a redirect-cause enum {NONE, EXP, JMP, BR, IRQ}.
REQ-038 The FIFO SHALL be a sub-module fetch_fifo (params WIDTH, DEPTH), with synchronous flush and a single-entry load port used by REQ-029.
REQ-039 The counter widths SHALL be $clog2(MAX_OUT+1) for outstanding and kill_cnt, and $clog2(DEPTH+1) for the FIFO count.

Verification
REQ-040 Streaming: hold imem_req_ready = 1, latency 1, id_ready = 1 from reset -> id_RF follows the returned data in order, with pc_RF = 0x80000004, 0x80000008, ... and one instruction per cycle after a 2-cycle fill.
REQ-041 Stall: drop id_ready for 6 cycles with DEPTH = 4 -> the FIFO fills to 4, imem_req_valid falls, id_RF holds, and the order is preserved on release.
REQ-042 Jump with 2 outstanding: assert jt with rd1 = 0x00001000 while pc[31] = 1 -> the next imem_addr is 0x00001000, the 2 stale responses are dropped, and the first id_RF is from 0x00001000 with pc_RF = 0x00001004.
REQ-043 Priority: assert exp, jt and irq in the same cycle -> pc = 0x80000004, the FIFO is empty, and no BNE_XP_INSN appears.
REQ-044 Interrupt: assert irq with head address 0x00000040 -> id_RF = 0x77DF0000 with pc_RF = 0x00000044, then fetch resumes at 0x80000008.
REQ-045 Reset mid-stream: assert reset with 2 outstanding and 3 queued -> the next cycle shows id_valid = 0, id_RF = 0x83FFF800, and imem_addr = 0x80000000.
